// File: rtl/ysyx_23060184_wbu_if.sv
// Result handshake bundle between the EXU/LSU producers and the writeback unit.
interface ysyx_23060184_wbu_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  exu_valid;
   logic                  exu_ready;
   logic [ADDR_WIDTH-1:0] exu_rd;
   logic [DATA_WIDTH-1:0] exu_data;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [ADDR_WIDTH-1:0] lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;

   // Producer side (EXU and LSU).
   modport master (
      output exu_valid, exu_rd, exu_data,
      input  exu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready
   );

   // Writeback side.
   modport slave (
      input  exu_valid, exu_rd, exu_data,
      output exu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready
   );
endinterface

// File: rtl/ysyx_23060184_wbu.sv
// Writeback unit: buffers EXU/LSU results in a small FIFO, retires one register-file
// write per cycle on registered outputs, and tracks in-flight destinations in a busy
// scoreboard for the issue stage's hazard stall.
module ysyx_23060184_wbu #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   ysyx_23060184_wbu_if.slave    res_if,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] q_rs1,
   input  logic [ADDR_WIDTH-1:0] q_rs2,
   input  logic [ADDR_WIDTH-1:0] q_rd,
   output logic                  q_stall,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  wb_idle
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned NREG = 1 << ADDR_WIDTH;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PW:0]           r_wptr;
   logic [PW:0]           r_rptr;
   logic [ADDR_WIDTH-1:0] r_mem_rd   [DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_waddr;
   logic [DATA_WIDTH-1:0] r_rf_wdata;

   logic [NREG-1:0]       r_busy;
   logic [NREG-1:0]       w_busy_d;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_lsu_acc;
   logic                  w_exu_acc;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_push_rd;
   logic [DATA_WIDTH-1:0] w_push_data;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

   assign res_if.lsu_ready = ~w_full;
   assign res_if.exu_ready = ~w_full & ~res_if.lsu_valid;

   // Arbitrate producers (LSU first) and decide push/pop for this cycle.
   always_comb begin
      w_lsu_acc   = res_if.lsu_valid & ~w_full;
      w_exu_acc   = res_if.exu_valid & ~w_full & ~res_if.lsu_valid;
      w_push_rd   = w_lsu_acc ? res_if.lsu_rd   : res_if.exu_rd;
      w_push_data = w_lsu_acc ? res_if.lsu_data : res_if.exu_data;
      // x0 results still handshake but never occupy the buffer.
      w_push      = (w_lsu_acc | w_exu_acc) & (w_push_rd != '0);
      w_pop       = ~w_empty;
   end

   // Advance FIFO pointers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
      end
   end

   // Write the accepted result at the tail; storage needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wptr[PW-1:0]]   <= w_push_rd;
         r_mem_data[r_wptr[PW-1:0]] <= w_push_data;
      end
   end

   // Register the popped head onto the register-file write port.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rf_wen   <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else if (w_pop) begin
         r_rf_wen   <= 1'b1;
         r_rf_waddr <= r_mem_rd[r_rptr[PW-1:0]];
         r_rf_wdata <= r_mem_data[r_rptr[PW-1:0]];
      end else begin
         r_rf_wen   <= 1'b0;
      end
   end

   // Scoreboard next state: retiring write clears, issue sets (set wins), x0 never busy.
   always_comb begin
      w_busy_d = r_busy;
      if (r_rf_wen) w_busy_d[r_rf_waddr] = 1'b0;
      if (iss_valid) w_busy_d[iss_rd] = 1'b1;
      w_busy_d[0] = 1'b0;
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_busy <= '0;
      else       r_busy <= w_busy_d;
   end

   assign q_stall  = r_busy[q_rs1] | r_busy[q_rs2] | r_busy[q_rd];
   assign rf_wen   = r_rf_wen;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign wb_idle  = w_empty & ~r_rf_wen;
endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Self-checking bench for the writeback unit: directed vector table, hand sequences
// for multi-cycle corners, and a randomized run against a queue-based reference model.
module tb_ysyx_23060184_wbu;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2;

   logic          clk;
   logic          rstn;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic [AW-1:0] q_rs1;
   logic [AW-1:0] q_rs2;
   logic [AW-1:0] q_rd;
   logic          q_stall;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          wb_idle;

   ysyx_23060184_wbu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) res_if ();

   ysyx_23060184_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .res_if   (res_if),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .q_rs1    (q_rs1),
      .q_rs2    (q_rs2),
      .q_rd     (q_rd),
      .q_stall  (q_stall),
      .rf_wen   (rf_wen),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .wb_idle  (wb_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending writes in acceptance order, the registered write port,
   // and a plain array of busy flags.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          m_q[$];
   bit            m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   bit            m_busy[32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
   endtask

   task automatic model_check();
      bit lr;
      bit er;
      lr = (m_q.size() < DEPTH);
      er = lr && !res_if.lsu_valid;
      chk("m_lsu_ready", 64'(res_if.lsu_ready), 64'(lr));
      chk("m_exu_ready", 64'(res_if.exu_ready), 64'(er));
      chk("m_q_stall", 64'(q_stall), 64'(m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd]));
      chk("m_rf_wen", 64'(rf_wen), 64'(m_wen));
      chk("m_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("m_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("m_wb_idle", 64'(wb_idle), 64'((m_q.size() == 0) && !m_wen));
   endtask

   task automatic model_update();
      bit   lr;
      bit   have;
      ent_t e;
      ent_t h;
      lr   = (m_q.size() < DEPTH);
      have = 1'b0;
      e    = '0;
      if (res_if.lsu_valid && lr) begin
         e = '{rd: res_if.lsu_rd, data: res_if.lsu_data}; have = 1'b1;
      end else if (res_if.exu_valid && lr) begin
         e = '{rd: res_if.exu_rd, data: res_if.exu_data}; have = 1'b1;
      end
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (m_q.size() > 0) begin
         h       = m_q.pop_front();
         m_wen   = 1'b1;
         m_waddr = h.rd;
         m_wdata = h.data;
      end else begin
         m_wen = 1'b0;
      end
      if (have && e.rd != 0) m_q.push_back(e);
   endtask

   // One clock: compare against the model at the falling edge, advance both at the
   // rising edge, return just after it.
   task automatic cycle();
      @(negedge clk);
      if (rstn) model_check();
      @(posedge clk);
      if (rstn) model_update();
      else model_reset();
      #1;
   endtask

   task automatic idle_inputs();
      res_if.exu_valid = 1'b0; res_if.exu_rd = '0; res_if.exu_data = '0;
      res_if.lsu_valid = 1'b0; res_if.lsu_rd = '0; res_if.lsu_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   typedef struct {
      bit            is_lsu;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      bit            exp_wen;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [AW-1:0] got_rd[$];
      logic [DW-1:0] got_dat[$];

      vecs[0] = '{is_lsu: 1'b0, rd: 5'd5,  data: 32'hDEAD_BEEF, exp_wen: 1'b1};
      vecs[1] = '{is_lsu: 1'b1, rd: 5'd9,  data: 32'h1234_5678, exp_wen: 1'b1};
      vecs[2] = '{is_lsu: 1'b0, rd: 5'd0,  data: 32'h0000_0005, exp_wen: 1'b0};
      vecs[3] = '{is_lsu: 1'b1, rd: 5'd0,  data: 32'hAAAA_5555, exp_wen: 1'b0};
      vecs[4] = '{is_lsu: 1'b0, rd: 5'd31, data: 32'hFFFF_FFFF, exp_wen: 1'b1};
      vecs[5] = '{is_lsu: 1'b1, rd: 5'd1,  data: 32'h0000_0000, exp_wen: 1'b1};

      idle_inputs();
      q_rs1 = '0; q_rs2 = '0; q_rd = '0;
      rstn  = 1'b0;
      model_reset();
      #12;
      chk("rst_rf_wen", 64'(rf_wen), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      chk("rst_wb_idle", 64'(wb_idle), 64'd1);
      chk("rst_q_stall", 64'(q_stall), 64'd0);
      chk("rst_lsu_ready", 64'(res_if.lsu_ready), 64'd1);
      @(posedge clk); #1;
      rstn = 1'b1;

      // Single EXU write with the destination marked busy at issue.
      iss_valid = 1'b1; iss_rd = 5'd5;
      cycle();
      iss_valid = 1'b0; q_rs1 = 5'd5;
      cycle();
      res_if.exu_valid = 1'b1; res_if.exu_rd = 5'd5; res_if.exu_data = 32'hDEAD_BEEF;
      #1 chk("s1_exu_ready", 64'(res_if.exu_ready), 64'd1);
      chk("s1_stall_issued", 64'(q_stall), 64'd1);
      cycle();
      res_if.exu_valid = 1'b0;
      #1 chk("s1_wen_e0", 64'(rf_wen), 64'd0);
      cycle();
      #1 chk("s1_wen_e1", 64'(rf_wen), 64'd1);
      chk("s1_waddr", 64'(rf_waddr), 64'd5);
      chk("s1_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
      chk("s1_stall_e1", 64'(q_stall), 64'd1);
      cycle();
      #1 chk("s1_stall_e2", 64'(q_stall), 64'd0);
      chk("s1_idle_e2", 64'(wb_idle), 64'd1);
      q_rs1 = '0;

      // Vector table: one result from idle, expected on the write port two edges later.
      foreach (vecs[i]) begin
         if (vecs[i].is_lsu) begin
            res_if.lsu_valid = 1'b1; res_if.lsu_rd = vecs[i].rd; res_if.lsu_data = vecs[i].data;
            #1 chk("tab_lsu_ready", 64'(res_if.lsu_ready), 64'd1);
         end else begin
            res_if.exu_valid = 1'b1; res_if.exu_rd = vecs[i].rd; res_if.exu_data = vecs[i].data;
            #1 chk("tab_exu_ready", 64'(res_if.exu_ready), 64'd1);
         end
         cycle();
         idle_inputs();
         cycle();
         #1 chk("tab_wen", 64'(rf_wen), 64'(vecs[i].exp_wen));
         chk("tab_idle", 64'(wb_idle), 64'(!vecs[i].exp_wen));
         if (vecs[i].exp_wen) begin
            chk("tab_waddr", 64'(rf_waddr), 64'(vecs[i].rd));
            chk("tab_wdata", 64'(rf_wdata), 64'(vecs[i].data));
         end
         cycle();
      end

      // Simultaneous producers: LSU wins, EXU follows, retire order 4 then 3.
      res_if.exu_valid = 1'b1; res_if.exu_rd = 5'd3; res_if.exu_data = 32'h11;
      res_if.lsu_valid = 1'b1; res_if.lsu_rd = 5'd4; res_if.lsu_data = 32'h22;
      #1 chk("sim_exu_ready0", 64'(res_if.exu_ready), 64'd0);
      chk("sim_lsu_ready0", 64'(res_if.lsu_ready), 64'd1);
      cycle();
      res_if.lsu_valid = 1'b0;
      #1 chk("sim_exu_ready1", 64'(res_if.exu_ready), 64'd1);
      cycle();
      res_if.exu_valid = 1'b0;
      #1 chk("sim_first_addr", 64'(rf_waddr), 64'd4);
      chk("sim_first_wen", 64'(rf_wen), 64'd1);
      cycle();
      #1 chk("sim_second_addr", 64'(rf_waddr), 64'd3);
      chk("sim_second_data", 64'(rf_wdata), 64'h11);
      cycle();
      #1 chk("sim_done_wen", 64'(rf_wen), 64'd0);

      // Back-to-back LSU stream of three results: none lost, order kept.
      for (int i = 0; i < 3; i++) begin
         res_if.lsu_valid = 1'b1; res_if.lsu_rd = AW'(10 + i); res_if.lsu_data = 32'hA0 + i;
         #1 chk("bp_lsu_ready", 64'(res_if.lsu_ready), 64'd1);
         cycle();
         if (rf_wen) begin got_rd.push_back(rf_waddr); got_dat.push_back(rf_wdata); end
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (rf_wen) begin got_rd.push_back(rf_waddr); got_dat.push_back(rf_wdata); end
      end
      chk("bp_count", 64'(got_rd.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_rd.size(); i++) begin
         chk("bp_addr", 64'(got_rd[i]), 64'(10 + i));
         chk("bp_data", 64'(got_dat[i]), 64'(32'hA0 + i));
      end

      // x0 result: handshake completes, nothing written, x0 never busy.
      res_if.exu_valid = 1'b1; res_if.exu_rd = '0; res_if.exu_data = 32'h5;
      iss_valid = 1'b1; iss_rd = '0; q_rs1 = '0;
      #1 chk("x0_exu_ready", 64'(res_if.exu_ready), 64'd1);
      cycle();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         #1 chk("x0_wen", 64'(rf_wen), 64'd0);
         chk("x0_idle", 64'(wb_idle), 64'd1);
         chk("x0_stall", 64'(q_stall), 64'd0);
         cycle();
      end

      // Same-cycle set and clear of x7: set wins.
      iss_valid = 1'b1; iss_rd = 5'd7;
      cycle();
      iss_valid = 1'b0;
      res_if.exu_valid = 1'b1; res_if.exu_rd = 5'd7; res_if.exu_data = 32'h77;
      cycle();
      res_if.exu_valid = 1'b0;
      cycle();
      iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7;
      #1 chk("sc_wen", 64'(rf_wen), 64'd1);
      chk("sc_waddr", 64'(rf_waddr), 64'd7);
      cycle();
      iss_valid = 1'b0;
      #1 chk("sc_busy_after", 64'(q_stall), 64'd1);
      cycle();
      #1 chk("sc_busy_hold", 64'(q_stall), 64'd1);

      // Asynchronous reset with a write pending on the port and an entry buffered.
      iss_valid = 1'b1; iss_rd = 5'd9;
      cycle();
      iss_valid = 1'b0;
      res_if.lsu_valid = 1'b1; res_if.lsu_rd = 5'd9; res_if.lsu_data = 32'h99;
      cycle();
      res_if.lsu_data = 32'h9A;
      cycle();
      idle_inputs();
      q_rs1 = 5'd7; q_rs2 = 5'd9; q_rd = 5'd9;
      #1 chk("ar_pre_wen", 64'(rf_wen), 64'd1);
      chk("ar_pre_stall", 64'(q_stall), 64'd1);
      #1 rstn = 1'b0;
      #1 chk("ar_wen", 64'(rf_wen), 64'd0);
      chk("ar_idle", 64'(wb_idle), 64'd1);
      chk("ar_stall", 64'(q_stall), 64'd0);
      model_reset();
      #3 rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         #1 chk("ar_no_write", 64'(rf_wen), 64'd0);
      end
      q_rs1 = '0; q_rs2 = '0; q_rd = '0;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         res_if.lsu_valid = 1'($urandom_range(0, 2) == 0);
         res_if.lsu_rd    = AW'($urandom_range(0, 31));
         res_if.lsu_data  = $urandom;
         res_if.exu_valid = 1'($urandom_range(0, 1));
         res_if.exu_rd    = AW'($urandom_range(0, 31));
         res_if.exu_data  = $urandom;
         iss_valid        = 1'($urandom_range(0, 3) == 0);
         iss_rd           = AW'($urandom_range(0, 31));
         q_rs1            = AW'($urandom_range(0, 31));
         q_rs2            = AW'($urandom_range(0, 31));
         q_rd             = AW'($urandom_range(0, 31));
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
